// File: rtl/coco_kbd_pkg.sv
// Shared types, scan-code constants and modifier classification for the CoCo 3 keyboard matrix.
package coco_kbd_pkg;

  localparam int KBD_ROWS = 7;
  localparam int KBD_COLS = 8;

  // Set-2 scan codes that need special handling
  localparam logic [7:0] SHIFT_L = 8'h12;
  localparam logic [7:0] SHIFT_R = 8'h59;
  localparam logic [7:0] CTRL    = 8'h14;
  localparam logic [7:0] ALT     = 8'h11;
  localparam logic [7:0] DEL     = 8'h71;
  localparam logic [7:0] ESC     = 8'h76;

  localparam logic [2:0] ROW_MOD   = 3'd6;
  localparam logic [2:0] COL_ALT   = 3'd3;
  localparam logic [2:0] COL_CTRL  = 3'd4;
  localparam logic [2:0] COL_SHIFT = 3'd7;

  typedef struct packed {
    logic       valid;
    logic [2:0] row;
    logic [2:0] col;
  } kbd_pos_t;

  typedef struct packed {
    logic lshift;
    logic rshift;
    logic lctrl;
    logic rctrl;
    logic lalt;
    logic ralt;
  } kbd_mods_t;

  typedef enum logic [2:0] {
    MOD_NONE,
    MOD_LSHIFT,
    MOD_RSHIFT,
    MOD_LCTRL,
    MOD_RCTRL,
    MOD_LALT,
    MOD_RALT
  } mod_sel_t;

  function automatic kbd_pos_t kbd_pos(input logic [2:0] row, input logic [2:0] col);
    kbd_pos_t p;
    p.valid = 1'b1;
    p.row   = row;
    p.col   = col;
    return p;
  endfunction

  // Left/right sides share a matrix bit but are tracked in separate flops
  function automatic mod_sel_t mod_classify(input logic ext, input logic [7:0] code);
    mod_sel_t m;
    m = MOD_NONE;
    if (!ext && code == SHIFT_L)     m = MOD_LSHIFT;
    else if (!ext && code == SHIFT_R) m = MOD_RSHIFT;
    else if (code == CTRL)           m = ext ? MOD_RCTRL : MOD_LCTRL;
    else if (code == ALT)            m = ext ? MOD_RALT : MOD_LALT;
    return m;
  endfunction

endpackage

// File: rtl/coco_kbd_matrix_if.sv
// Host-side bundle: ps2_key events and PIA strobes in, row sense and status out.
interface coco_kbd_matrix_if;
  logic [10:0] ps2_key;
  logic [7:0]  col_n;
  logic [6:0]  rows_n;
  logic        any_key;
  logic        kbd_reset;

  modport master (
    output ps2_key, col_n,
    input  rows_n, any_key, kbd_reset
  );

  modport slave (
    input  ps2_key, col_n,
    output rows_n, any_key, kbd_reset
  );
endinterface

// File: rtl/coco_kbd_decode.sv
// Combinational map from {E0-extended, set-2 code} to a CoCo 3 matrix position.
module coco_kbd_decode
  import coco_kbd_pkg::*;
(
  input  logic       ext_i,
  input  logic [7:0] code_i,
  output kbd_pos_t   pos_o
);

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    pos_o = '0;
    if (!ext_i) begin
      case (code_i)
        8'h54: pos_o = kbd_pos(3'd0, 3'd0);  // '[' stands in for @
        8'h1C: pos_o = kbd_pos(3'd0, 3'd1);
        8'h32: pos_o = kbd_pos(3'd0, 3'd2);
        8'h21: pos_o = kbd_pos(3'd0, 3'd3);
        8'h23: pos_o = kbd_pos(3'd0, 3'd4);
        8'h24: pos_o = kbd_pos(3'd0, 3'd5);
        8'h2B: pos_o = kbd_pos(3'd0, 3'd6);
        8'h34: pos_o = kbd_pos(3'd0, 3'd7);
        8'h33: pos_o = kbd_pos(3'd1, 3'd0);
        8'h43: pos_o = kbd_pos(3'd1, 3'd1);
        8'h3B: pos_o = kbd_pos(3'd1, 3'd2);
        8'h42: pos_o = kbd_pos(3'd1, 3'd3);
        8'h4B: pos_o = kbd_pos(3'd1, 3'd4);
        8'h3A: pos_o = kbd_pos(3'd1, 3'd5);
        8'h31: pos_o = kbd_pos(3'd1, 3'd6);
        8'h44: pos_o = kbd_pos(3'd1, 3'd7);
        8'h4D: pos_o = kbd_pos(3'd2, 3'd0);
        8'h15: pos_o = kbd_pos(3'd2, 3'd1);
        8'h2D: pos_o = kbd_pos(3'd2, 3'd2);
        8'h1B: pos_o = kbd_pos(3'd2, 3'd3);
        8'h2C: pos_o = kbd_pos(3'd2, 3'd4);
        8'h3C: pos_o = kbd_pos(3'd2, 3'd5);
        8'h2A: pos_o = kbd_pos(3'd2, 3'd6);
        8'h1D: pos_o = kbd_pos(3'd2, 3'd7);
        8'h22: pos_o = kbd_pos(3'd3, 3'd0);
        8'h35: pos_o = kbd_pos(3'd3, 3'd1);
        8'h1A: pos_o = kbd_pos(3'd3, 3'd2);
        8'h29: pos_o = kbd_pos(3'd3, 3'd7);
        8'h45: pos_o = kbd_pos(3'd4, 3'd0);
        8'h16: pos_o = kbd_pos(3'd4, 3'd1);
        8'h1E: pos_o = kbd_pos(3'd4, 3'd2);
        8'h26: pos_o = kbd_pos(3'd4, 3'd3);
        8'h25: pos_o = kbd_pos(3'd4, 3'd4);
        8'h2E: pos_o = kbd_pos(3'd4, 3'd5);
        8'h36: pos_o = kbd_pos(3'd4, 3'd6);
        8'h3D: pos_o = kbd_pos(3'd4, 3'd7);
        8'h3E: pos_o = kbd_pos(3'd5, 3'd0);
        8'h46: pos_o = kbd_pos(3'd5, 3'd1);
        8'h52: pos_o = kbd_pos(3'd5, 3'd2);  // quote key stands in for ':'
        8'h4C: pos_o = kbd_pos(3'd5, 3'd3);
        8'h41: pos_o = kbd_pos(3'd5, 3'd4);
        8'h4E: pos_o = kbd_pos(3'd5, 3'd5);
        8'h49: pos_o = kbd_pos(3'd5, 3'd6);
        8'h4A: pos_o = kbd_pos(3'd5, 3'd7);
        8'h5A: pos_o = kbd_pos(ROW_MOD, 3'd0);
        ESC:   pos_o = kbd_pos(ROW_MOD, 3'd2);
        ALT:   pos_o = kbd_pos(ROW_MOD, COL_ALT);
        CTRL:  pos_o = kbd_pos(ROW_MOD, COL_CTRL);
        8'h05: pos_o = kbd_pos(ROW_MOD, 3'd5);
        8'h06: pos_o = kbd_pos(ROW_MOD, 3'd6);
        SHIFT_L, SHIFT_R: pos_o = kbd_pos(ROW_MOD, COL_SHIFT);
        default: pos_o = '0;
      endcase
    end else begin
      // Extended codes: arrows, Home and the right-hand modifiers only
      case (code_i)
        8'h75: pos_o = kbd_pos(3'd3, 3'd3);
        8'h72: pos_o = kbd_pos(3'd3, 3'd4);
        8'h6B: pos_o = kbd_pos(3'd3, 3'd5);
        8'h74: pos_o = kbd_pos(3'd3, 3'd6);
        8'h6C: pos_o = kbd_pos(ROW_MOD, 3'd1);
        ALT:   pos_o = kbd_pos(ROW_MOD, COL_ALT);
        CTRL:  pos_o = kbd_pos(ROW_MOD, COL_CTRL);
        default: pos_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/coco_kbd_matrix.sv
// ps2_key events to CoCo 3 keyboard matrix with registered row sense.
// Optional Ctrl+Alt+Del reset pulse enabled by defining COCO_KBD_CAD_RESET_EN.
module coco_kbd_matrix
  import coco_kbd_pkg::*;
#(
  parameter int RESET_CYCLES = 16
) (
  input  logic               clk_sys,
  input  logic               reset,
  coco_kbd_matrix_if.slave   kbd
);

  logic       tog_q;
  logic       ev_q;
  logic [9:0] key_q;   // {make, ext, code} of the captured event

  kbd_pos_t   pos;
  mod_sel_t   mod;
  logic       ev_make;
  logic       ev_ext;
  logic [7:0] ev_code;

  logic [KBD_ROWS-1:0][KBD_COLS-1:0] matrix_q, matrix_d;
  kbd_mods_t mods_q, mods_d;
  logic [KBD_ROWS-1:0] rows_n_q, rows_n_d;
  logic                any_key_q, any_key_d;

  // Stage 1: capture the event word on a toggle of bit 10
  always_ff @(posedge clk_sys) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      tog_q <= kbd.ps2_key[10];
      ev_q  <= 1'b0;
      key_q <= '0;
    end else begin
      tog_q <= kbd.ps2_key[10];
      ev_q  <= kbd.ps2_key[10] != tog_q;
      key_q <= kbd.ps2_key[9:0];
    end
  end

  assign ev_make = key_q[9];
  assign ev_ext  = key_q[8];
  assign ev_code = key_q[7:0];
  assign mod     = mod_classify(ev_ext, ev_code);

  coco_kbd_decode u_decode (
    .ext_i  (ev_ext),
    .code_i (ev_code),
    .pos_o  (pos)
  );

  // Stage 2: matrix and modifier update
  always_comb begin
    matrix_d = matrix_q;
    mods_d   = mods_q;
    if (ev_q) begin
      case (mod)
        MOD_LSHIFT: mods_d.lshift = ev_make;
        MOD_RSHIFT: mods_d.rshift = ev_make;
        MOD_LCTRL:  mods_d.lctrl  = ev_make;
        MOD_RCTRL:  mods_d.rctrl  = ev_make;
        MOD_LALT:   mods_d.lalt   = ev_make;
        MOD_RALT:   mods_d.ralt   = ev_make;
        MOD_NONE:   if (pos.valid) matrix_d[pos.row][pos.col] = ev_make;
        default:    ;
      endcase
    end
    // Modifier bits follow the OR of both sides so one release cannot drop a held key
    matrix_d[ROW_MOD][COL_SHIFT] = mods_d.lshift | mods_d.rshift;
    matrix_d[ROW_MOD][COL_CTRL]  = mods_d.lctrl  | mods_d.rctrl;
    matrix_d[ROW_MOD][COL_ALT]   = mods_d.lalt   | mods_d.ralt;
  end

  always_ff @(posedge clk_sys) begin
    // NOTE: the matrix is a handful of flops, not a RAM, and must read all-released after reset.
    if (reset) begin
      matrix_q <= '0;
      mods_q   <= '0;
    end else begin
      matrix_q <= matrix_d;
      mods_q   <= mods_d;
    end
  end

  // Stage 3: row sense against the currently strobed columns
  always_comb begin
    rows_n_d  = '1;
    any_key_d = |matrix_q;
    for (int r = 0; r < KBD_ROWS; r++) begin
      rows_n_d[r] = ~|(matrix_q[r] & ~kbd.col_n);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      rows_n_q  <= '1;
      any_key_q <= 1'b0;
    end else begin
      rows_n_q  <= rows_n_d;
      any_key_q <= any_key_d;
    end
  end

  assign kbd.rows_n  = rows_n_q;
  assign kbd.any_key = any_key_q;

`ifdef COCO_KBD_CAD_RESET_EN
  localparam int CNT_W = $clog2(RESET_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cad_hit;

  // Del never reaches the matrix; it only arms the pulse when CTRL and ALT are down
  assign cad_hit = ev_q && ev_make && ev_ext && (ev_code == DEL) &&
                   (mods_q.lctrl | mods_q.rctrl) && (mods_q.lalt | mods_q.ralt);

  always_comb begin
    cnt_d = cnt_q;
    if (cad_hit) begin
      cnt_d = CNT_W'(RESET_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign kbd.kbd_reset = |cnt_q;
`else
  assign kbd.kbd_reset = 1'b0;
`endif

endmodule

// File: tb/tb_coco_kbd_matrix.sv
// Directed scoreboard bench: stimulus queues cycle-stamped expectations, a negedge monitor compares.
module tb_coco_kbd_matrix;

`ifdef COCO_KBD_CAD_RESET_EN
  localparam bit CAD = 1'b1;
`else
  localparam bit CAD = 1'b0;
`endif

  typedef struct {
    int         cyc;
    logic [6:0] rows_n;
    logic       any_key;
    logic       kbd_reset;
    bit         only_kr;
    string      name;
  } exp_t;

  logic clk;
  logic reset;
  logic tog;
  int   cyc;
  int   total;
  int   bad;
  exp_t sb[$];

  coco_kbd_matrix_if kbd_if ();

  coco_kbd_matrix #(.RESET_CYCLES(16)) dut (
    .clk_sys (clk),
    .reset   (reset),
    .kbd     (kbd_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Insert keeping the queue ordered by target cycle
  function automatic void push(input exp_t e);
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].cyc > e.cyc) begin
        sb.insert(i, e);
        return;
      end
    end
    sb.push_back(e);
  endfunction

  function automatic void exp_out(input int c, input logic [6:0] r, input logic a,
                                  input logic k, input string nm);
    exp_t e;
    e.cyc = c; e.rows_n = r; e.any_key = a; e.kbd_reset = k; e.only_kr = 1'b0; e.name = nm;
    push(e);
  endfunction

  function automatic void exp_kr(input int c, input logic k, input string nm);
    exp_t e;
    e.cyc = c; e.rows_n = '1; e.any_key = 1'b0; e.kbd_reset = k; e.only_kr = 1'b1; e.name = nm;
    push(e);
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic make, input logic ext, input logic [7:0] code);
    tog = ~tog;
    kbd_if.ps2_key = {tog, make, ext, code};
  endtask

  // Monitor: compare every expectation due this cycle
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      total++;
      if (e.cyc < cyc) begin
        bad++;
        $display("FAIL %s: expectation for cycle %0d missed (now %0d)", e.name, e.cyc, cyc);
      end else if (e.only_kr) begin
        if (kbd_if.kbd_reset !== e.kbd_reset) begin
          bad++;
          $display("FAIL %s @%0d: kbd_reset got %b want %b", e.name, cyc, kbd_if.kbd_reset,
                   e.kbd_reset);
        end
      end else if (kbd_if.rows_n !== e.rows_n || kbd_if.any_key !== e.any_key ||
                   kbd_if.kbd_reset !== e.kbd_reset) begin
        bad++;
        $display("FAIL %s @%0d: rows_n=%h any_key=%b kbd_reset=%b, want rows_n=%h any_key=%b kbd_reset=%b",
                 e.name, cyc, kbd_if.rows_n, kbd_if.any_key, kbd_if.kbd_reset,
                 e.rows_n, e.any_key, e.kbd_reset);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    int d;
    int j;
    total = 0;
    bad   = 0;
    tog   = 1'b0;
    reset = 1'b1;
    kbd_if.ps2_key = '0;
    kbd_if.col_n   = 8'hFF;
    exp_out(2, 7'h7F, 1'b0, 1'b0, "reset_state");
    step(3);
    reset = 1'b0;
    step(1);

    // A make/break, column 1 strobed
    k = cyc;
    kbd_if.col_n = 8'hFD;
    send(1'b1, 1'b0, 8'h1C);
    exp_out(k + 1, 7'h7F, 1'b0, 1'b0, "idle_col");
    exp_out(k + 2, 7'h7F, 1'b0, 1'b0, "a_latency");
    exp_out(k + 3, 7'h7E, 1'b1, 1'b0, "a_make");
    step(4);
    k = cyc;
    send(1'b0, 1'b0, 8'h1C);
    exp_out(k + 3, 7'h7F, 1'b0, 1'b0, "a_break");
    step(4);

    // Left and right shift tracked separately
    k = cyc;
    kbd_if.col_n = 8'h7F;
    send(1'b1, 1'b0, 8'h12);
    step(1);
    send(1'b1, 1'b0, 8'h59);
    step(1);
    send(1'b0, 1'b0, 8'h12);
    exp_out(k + 3, 7'h3F, 1'b1, 1'b0, "lshift");
    exp_out(k + 5, 7'h3F, 1'b1, 1'b0, "rshift_held");
    step(4);
    k = cyc;
    send(1'b0, 1'b0, 8'h59);
    exp_out(k + 3, 7'h7F, 1'b0, 1'b0, "shift_clear");
    step(4);

    // Extended UP vs keypad 8
    k = cyc;
    kbd_if.col_n = 8'hF7;
    send(1'b1, 1'b1, 8'h75);
    step(1);
    send(1'b1, 1'b0, 8'h75);
    exp_out(k + 3, 7'h77, 1'b1, 1'b0, "up_make");
    exp_out(k + 4, 7'h77, 1'b1, 1'b0, "kp8_ignored");
    step(3);
    kbd_if.col_n = 8'h00;
    exp_out(k + 5, 7'h77, 1'b1, 1'b0, "up_all_cols");
    step(1);
    send(1'b0, 1'b1, 8'h75);
    exp_out(k + 8, 7'h7F, 1'b0, 1'b0, "up_break");
    step(4);

    // A and SPACE on consecutive cycles, then column strobe response
    k = cyc;
    send(1'b1, 1'b0, 8'h1C);
    step(1);
    send(1'b1, 1'b0, 8'h29);
    exp_out(k + 3, 7'h7E, 1'b1, 1'b0, "a_first");
    exp_out(k + 4, 7'h76, 1'b1, 1'b0, "a_space");
    step(4);
    kbd_if.col_n = 8'hFD;
    exp_out(k + 6, 7'h7E, 1'b1, 1'b0, "col_a_only");
    step(1);
    kbd_if.col_n = 8'h7F;
    exp_out(k + 7, 7'h77, 1'b1, 1'b0, "col_space_only");
    step(1);
    kbd_if.col_n = 8'h00;
    send(1'b0, 1'b0, 8'h1C);
    step(1);
    send(1'b0, 1'b0, 8'h29);
    j = cyc;
    exp_out(j + 3, 7'h7F, 1'b0, 1'b0, "keys_released");
    step(4);

    // Ctrl+Alt+Del: 16-cycle pulse when built in, Del absent from matrix
    send(1'b1, 1'b0, 8'h14);
    step(1);
    send(1'b1, 1'b0, 8'h11);
    step(1);
    d = cyc;
    send(1'b1, 1'b1, 8'h71);
    exp_out(d + 3, 7'h3F, 1'b1, CAD, "cad_no_del");
    for (int i = 1; i <= 18; i++) begin
      exp_kr(d + i, CAD && i >= 2 && i <= 17, "cad_pulse");
    end
    step(18);
    send(1'b0, 1'b1, 8'h71);
    step(1);
    send(1'b0, 1'b0, 8'h11);
    step(1);
    send(1'b0, 1'b0, 8'h14);
    j = cyc;
    exp_out(j + 3, 7'h7F, 1'b0, 1'b0, "cad_release");
    step(4);

    // Reset mid-pulse with an event toggle in the reset cycle
    send(1'b1, 1'b0, 8'h14);
    step(1);
    send(1'b1, 1'b0, 8'h11);
    step(1);
    d = cyc;
    send(1'b1, 1'b1, 8'h71);
    step(4);
    reset = 1'b1;
    send(1'b1, 1'b0, 8'h1C);
    exp_out(d + 4, 7'h3F, 1'b1, CAD, "pulse_before_reset");
    exp_out(d + 5, 7'h7F, 1'b0, 1'b0, "reset_mid_pulse");
    step(1);
    reset = 1'b0;
    exp_out(d + 8, 7'h7F, 1'b0, 1'b0, "no_spurious_event");
    exp_out(d + 10, 7'h7F, 1'b0, 1'b0, "still_clear");
    step(8);

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left unchecked", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
